// File: rtl/array_update_pipe.sv
// Pipelined array rewrite: stage 0 captures the raw transaction, the ordered updates are applied
// combinationally on it, and the result rides a valid/ready register chain to the output.
module array_update_pipe #(
    parameter int unsigned ELEM_W      = 33,
    parameter int unsigned NUM_ELEMS   = 4,
    parameter int unsigned NUM_UPDATES = 2,
    parameter int unsigned IDX_W       = 32,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEM_W*NUM_ELEMS-1:0]   x,
    input  logic [NUM_UPDATES-1:0]        upd_en,
    input  logic [NUM_UPDATES*IDX_W-1:0]  upd_idx,
    input  logic [NUM_UPDATES*ELEM_W-1:0] upd_val,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ELEM_W*NUM_ELEMS-1:0]   out,
    output logic [NUM_UPDATES-1:0]        out_oob
);
    localparam int unsigned ArrW = ELEM_W * NUM_ELEMS;

    logic [LATENCY-1:0]            v_q, v_d;
    logic [LATENCY-1:0]            ld;
    logic [ArrW-1:0]               x_q;
    logic [NUM_UPDATES-1:0]        en_q;
    logic [NUM_UPDATES*IDX_W-1:0]  idx_q;
    logic [NUM_UPDATES*ELEM_W-1:0] val_q;
    logic [ArrW-1:0]               res;
    logic [NUM_UPDATES-1:0]        oob;

    // Stage i may load when downstream drains or any stage from i onward holds a bubble.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            ld[i] = out_ready;
            for (int j = i; j < LATENCY; j++) begin
                if (!v_q[j]) ld[i] = 1'b1;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LATENCY-1];

    always_comb begin
        v_d = v_q;
        if (ld[0]) v_d[0] = in_valid;
        for (int i = 1; i < LATENCY; i++) begin
            if (ld[i]) v_d[i] = v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld[0]) begin
            x_q   <= x;
            en_q  <= upd_en;
            idx_q <= upd_idx;
            val_q <= upd_val;
        end
    end

    // Updates applied in port order so the highest enabled port wins on a shared index.
    always_comb begin
        res = x_q;
        oob = '0;
        for (int u = 0; u < NUM_UPDATES; u++) begin
            if (en_q[u]) begin
                oob[u] = 1'b1;
                for (int k = 0; k < NUM_ELEMS; k++) begin
                    if (idx_q[u*IDX_W +: IDX_W] == IDX_W'(k)) begin
                        res[k*ELEM_W +: ELEM_W] = val_q[u*ELEM_W +: ELEM_W];
                        oob[u]                  = 1'b0;
                    end
                end
            end
        end
    end

    if (LATENCY > 1) begin : g_stages
        logic [ArrW-1:0]        arr_q [LATENCY-1];
        logic [NUM_UPDATES-1:0] oob_q [LATENCY-1];

        always_ff @(posedge clk) begin
            if (ld[1]) begin
                arr_q[0] <= res;
                oob_q[0] <= oob;
            end
            for (int i = 1; i < LATENCY - 1; i++) begin
                if (ld[i+1]) begin
                    arr_q[i] <= arr_q[i-1];
                    oob_q[i] <= oob_q[i-1];
                end
            end
        end

        assign out     = arr_q[LATENCY-2];
        assign out_oob = oob_q[LATENCY-2];
    end else begin : g_comb
        assign out     = res;
        assign out_oob = oob;
    end

endmodule

// File: tb/tb_array_update_pipe.sv
// Bench for array_update_pipe: directed cases plus random traffic scored against an
// element-array reference model and an in-flight queue.
module tb_array_update_pipe;
    localparam int EW  = 33;
    localparam int NE  = 4;
    localparam int NU  = 2;
    localparam int IW  = 32;
    localparam int LAT = 2;
    localparam int AW  = EW * NE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0]  x, out;
    logic [NU-1:0]  upd_en, out_oob;
    logic [NU*IW-1:0] upd_idx;
    logic [NU*EW-1:0] upd_val;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [32:0] b_x, b_out;
    logic [2:0]  b_en, b_oob;
    logic [95:0] b_idx;
    logic [98:0] b_val;

    array_update_pipe #(
        .ELEM_W(EW), .NUM_ELEMS(NE), .NUM_UPDATES(NU), .IDX_W(IW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_val(upd_val), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_oob(out_oob)
    );

    array_update_pipe #(
        .ELEM_W(33), .NUM_ELEMS(1), .NUM_UPDATES(3), .IDX_W(32), .LATENCY(1)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
        .upd_en(b_en), .upd_idx(b_idx), .upd_val(b_val), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out(b_out), .out_oob(b_oob)
    );

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int emitted = 0;
    logic [AW-1:0] exp_q[$];
    logic [NU-1:0] oob_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [AW-1:0] xa, input logic [NU-1:0] en,
                                  input logic [NU*IW-1:0] idx, input logic [NU*EW-1:0] val,
                                  output logic [AW-1:0] res, output logic [NU-1:0] oob);
        logic [EW-1:0] elem [NE];
        logic [IW-1:0] ix;
        for (int k = 0; k < NE; k++) elem[k] = xa[k*EW +: EW];
        oob = '0;
        for (int u = 0; u < NU; u++) begin
            ix = idx[u*IW +: IW];
            if (en[u]) begin
                if (ix < IW'(NE)) elem[int'(ix)] = val[u*EW +: EW];
                else oob[u] = 1'b1;
            end
        end
        for (int k = 0; k < NE; k++) res[k*EW +: EW] = elem[k];
    endfunction

    function automatic logic [AW-1:0] pack4(input logic [EW-1:0] e3, input logic [EW-1:0] e2,
                                            input logic [EW-1:0] e1, input logic [EW-1:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [IW-1:0] rand_idx();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 5) return IW'(r);
        if (r == 5) return 32'hFFFF_FFFF;
        return IW'($urandom);
    endfunction

    function automatic logic [EW-1:0] rand_val();
        return {1'($urandom), 32'($urandom)};
    endfunction

    task automatic rand_txn();
        x       = AW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        upd_en  = NU'($urandom);
        upd_idx = {rand_idx(), rand_idx()};
        upd_val = {rand_val(), rand_val()};
    endtask

    // One clock: score outputs and record acceptance at the falling edge, then cross the edge.
    task automatic tick();
        logic [AW-1:0] r;
        logic [NU-1:0] o;
        @(negedge clk);
        if (!rst) begin
            if (exp_q.size() == 0) begin
                check("empty_out_valid", 256'(out_valid), 256'(0));
                check("empty_in_ready", 256'(in_ready), 256'(1));
            end else if (exp_q.size() == LAT) begin
                check("full_out_valid", 256'(out_valid), 256'(1));
                check("full_in_ready", 256'(in_ready), 256'(out_ready));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 256'(out_valid), 256'(0));
                end else begin
                    check("out_data", 256'(out), 256'(exp_q[0]));
                    check("out_oob", 256'(out_oob), 256'(oob_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(oob_q.pop_front());
                        emitted++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(x, upd_en, upd_idx, upd_val, r, o);
                exp_q.push_back(r);
                oob_q.push_back(o);
                accepted++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] xs, e;
        int            sent;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; upd_en = '0; upd_idx = '0; upd_val = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_en = '0; b_idx = '0; b_val = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("b_rst_out_valid", 256'(b_out_valid), 256'(0));
        check("b_rst_in_ready", 256'(b_in_ready), 256'(1));

        // Single update, two-cycle latency
        x = pack4(33'd3, 33'd2, 33'd1, 33'd0);
        upd_en = 2'b01; upd_idx = {32'd0, 32'd1}; upd_val = {33'd0, 33'd42};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_not_yet", 256'(out_valid), 256'(0));
        tick();
        check("lat_valid", 256'(out_valid), 256'(1));
        check("t1_out", 256'(out), 256'(pack4(33'd3, 33'd2, 33'd42, 33'd0)));
        check("t1_oob", 256'(out_oob), 256'(0));
        tick();

        // Duplicate index: later port wins
        rand_txn();
        xs = x;
        upd_en = 2'b11; upd_idx = {32'd2, 32'd2}; upd_val = {33'd9, 33'd5};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        e = xs;
        e[2*EW +: EW] = 33'd9;
        check("dup_out", 256'(out), 256'(e));
        check("dup_oob", 256'(out_oob), 256'(0));
        tick();

        // Out of bounds, then the same indices disabled
        rand_txn();
        xs = x;
        upd_en = 2'b11; upd_idx = {32'hFFFF_FFFF, 32'd4};
        in_valid = 1'b1;
        tick();
        upd_en = 2'b00;
        tick();
        in_valid = 1'b0;
        check("oob_out", 256'(out), 256'(xs));
        check("oob_bits", 256'(out_oob), 256'(2'b11));
        tick();
        check("dis_out", 256'(out), 256'(xs));
        check("dis_bits", 256'(out_oob), 256'(2'b00));
        tick();

        // Back-to-back 8 with out_ready pattern 1,0,0,1
        accepted = 0; emitted = 0; sent = 0;
        for (int c = 0; c < 80 && (accepted < 8 || exp_q.size() > 0); c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            in_valid  = (accepted < 8);
            rand_txn();
            tick();
            sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("b2b_accepted", 256'(accepted), 256'(8));
        check("b2b_emitted", 256'(emitted), 256'(8));
        check("b2b_drained", 256'(exp_q.size()), 256'(0));

        // Reset with two transactions in flight
        out_ready = 1'b0; in_valid = 1'b1;
        rand_txn(); tick();
        rand_txn(); tick();
        check("pre_rst_full", 256'(exp_q.size()), 256'(2));
        rst = 1'b1;
        rand_txn(); tick();
        rst = 1'b0;
        exp_q.delete(); oob_q.delete();
        in_valid = 1'b0;
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            rand_txn();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
        check("rand_drained", 256'(exp_q.size()), 256'(0));

        // Single-element, three-port, latency-1 configuration
        b_x = 33'd5; b_en = 3'b111;
        b_idx = {32'd1, 32'd0, 32'd0}; b_val = {33'd9, 33'd8, 33'd7};
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("b_valid", 256'(b_out_valid), 256'(1));
        check("b_out", 256'(b_out), 256'(33'd8));
        check("b_oob", 256'(b_oob), 256'(3'b100));
        tick();
        check("b_done", 256'(b_out_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
